user_pulse_monitor: RTL and testbench
=====================================

USER_PULSE_MONITOR -- requirements
Module: user_pulse_monitor

Interface
REQ-001 SHALL have parameter CNT_W, 16, width of all cycle/pulse counters and measurement fields.
REQ-002 SHALL have parameter FIFO_DEPTH, 4, record FIFO entries; power of two, >=2.
REQ-003 SHALL have port clk_i  input  1  clock; all logic on rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port pulse_i  input  1  pulse waveform from the user pulser (same clock domain).
REQ-006 SHALL have port state_i  input  3  pulser state: 0 IDLE, 1 RUN_F1, 2 RUN_F2, 3 RUN_STOP, 4 DONE.
REQ-007 SHALL have port clear_i  input  1  synchronous clear of all state and FIFO.
REQ-008 SHALL have port rec_valid_o  output  1  FIFO head valid.
REQ-009 SHALL have port rec_ready_i  input  1  consumer accepts head.
REQ-010 SHALL have port rec_high_o  output  CNT_W  head record high width in cycles.
REQ-011 SHALL have port rec_period_o  output  CNT_W  head record rise-to-rise period in cycles.
REQ-012 SHALL have port pulse_cnt_o  output  CNT_W  rising edges counted in current/last run.
REQ-013 SHALL have port min_period_o / max_period_o  output  CNT_W each  extreme recorded periods of current/last run.
REQ-014 SHALL have port run_done_o  output  1  one-cycle pulse on run completion.
REQ-015 SHALL have port run_abort_o  output  1  one-cycle pulse on run abort.
REQ-016 SHALL have port overflow_o  output  1  sticky; a record was dropped.

Function
REQ-017 SHALL register pulse_i into pulse_q every cycle; rise = pulse_i & ~pulse_q, fall = ~pulse_i & pulse_q.
REQ-018 SHALL define active = state_i in {1,2,3}; edges while not active SHALL be ignored (pulse_q still updates).
REQ-019 SHALL detect run start when registered previous state was 0 and state_i != 0: clear pulse_cnt, first_seen, timers; min_period=all-ones, max_period=0; FIFO untouched.
REQ-020 SHALL count rises while active into pulse_cnt_o, saturating at all-ones.
REQ-021 SHALL, on each active rise at cycle t, restart high and period timers so that a fall at tf yields high width tf-t and next rise at t1 yields period t1-t; timers saturate at all-ones.
REQ-022 SHALL latch high width on fall; if no fall before next rise, high width SHALL equal the period.
REQ-023 SHALL, on an active rise with first_seen set, push record {high, period} and update min/max in that cycle; first rise of a run only sets first_seen.
REQ-024 SHALL present FIFO head on rec_* ; pop when rec_valid_o & rec_ready_i; rec_high_o/rec_period_o SHALL be 0 when empty.
REQ-025 SHALL drop a push when full and no pop that cycle, setting overflow_o; push and pop in the same cycle when full SHALL both succeed.
REQ-026 SHALL pulse run_done_o one cycle after the cycle state_i first equals 4 following an active cycle.
REQ-027 SHALL pulse run_abort_o one cycle after state_i goes from active directly to 0.
REQ-028 SHALL give clear_i priority over every other event in the same cycle; it restores all reset values.
REQ-029 SHALL hold pulse_cnt_o, min/max, overflow_o after run end until next run start or clear.

Reset
REQ-030 SHALL, while rst_ni low, drive: rec_valid_o=0, rec_high_o=0, rec_period_o=0, pulse_cnt_o=0, min_period_o=all-ones, max_period_o=0, run_done_o=0, run_abort_o=0, overflow_o=0; FIFO empty, pulse_q=0, first_seen=0.
REQ-031 SHALL accept reset assertion mid-run; after release, behaviour SHALL match power-up.

Verification
REQ-032 SHALL cover: state 1, pulse high 3/low 5 cycles, 4 pulses, rec_ready_i=1 -> 3 records {3,8}, pulse_cnt_o=4, min=max=8.
REQ-033 SHALL cover: rec_ready_i=0, 6 periodic pulses -> 4 records held, overflow_o=1, 5th record dropped; pop one then push same cycle when full -> no new drop.
REQ-034 SHALL cover: state 1->4->0 after 2 pulses -> run_done_o high exactly one cycle, pulse_cnt_o=2 held.
REQ-035 SHALL cover: state 2->0 mid-run -> run_abort_o one cycle, no run_done_o.
REQ-036 SHALL cover: clear_i asserted with simultaneous rise and push -> all outputs at reset values next cycle, no record.
REQ-037 SHALL cover: pulse_i held high 70000 cycles between rises -> period and high saturate at 16'hFFFF.

Source files
------------

// File: rtl/user_pulse_monitor.sv
// Measures high width and rise-to-rise period of a pulser waveform during active runs,
// queueing {high, period} records in a small FIFO and tracking run count and period extremes.
module user_pulse_monitor #(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             pulse_i,
  input  logic [2:0]       state_i,
  input  logic             clear_i,
  output logic             rec_valid_o,
  input  logic             rec_ready_i,
  output logic [CNT_W-1:0] rec_high_o,
  output logic [CNT_W-1:0] rec_period_o,
  output logic [CNT_W-1:0] pulse_cnt_o,
  output logic [CNT_W-1:0] min_period_o,
  output logic [CNT_W-1:0] max_period_o,
  output logic             run_done_o,
  output logic             run_abort_o,
  output logic             overflow_o
);

  localparam int unsigned AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] DepthCnt = (AW + 1)'(FIFO_DEPTH);
  localparam logic [2:0]  StIdle   = 3'd0;
  localparam logic [2:0]  StDone   = 3'd4;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  logic             pulse_q, pulse_d;
  logic [2:0]       state_q;
  logic             first_seen_q, first_seen_d;
  logic             fell_q, fell_d;
  logic [CNT_W-1:0] high_tmr_q, high_tmr_d;
  logic [CNT_W-1:0] per_tmr_q, per_tmr_d;
  logic [CNT_W-1:0] high_lat_q, high_lat_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] min_q, min_d;
  logic [CNT_W-1:0] max_q, max_d;
  logic             done_q, done_d;
  logic             abort_q, abort_d;
  logic             ovf_q, ovf_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [CNT_W-1:0] mem_high_q [FIFO_DEPTH];
  logic [CNT_W-1:0] mem_per_q  [FIFO_DEPTH];

  logic             active, prev_active, rise, fall, start;
  logic             push, pop, full, push_ok, drop;
  logic [CNT_W-1:0] rec_high;

  assign active      = state_i inside {3'd1, 3'd2, 3'd3};
  assign prev_active = state_q inside {3'd1, 3'd2, 3'd3};
  assign rise        = pulse_i & ~pulse_q & active;
  assign fall        = ~pulse_i & pulse_q & active;
  assign start       = (state_q == StIdle) && (state_i != StIdle);

  // Without a fall since the previous rise the pulse never went low: width equals period.
  assign rec_high = fell_q ? high_lat_q : per_tmr_q;

  assign push    = rise & first_seen_q & ~start;
  assign pop     = rec_valid_o & rec_ready_i;
  assign full    = (count_q == DepthCnt);
  assign push_ok = push & (~full | pop) & ~clear_i;
  assign drop    = push & full & ~pop;

  assign rec_valid_o  = (count_q != '0);
  assign rec_high_o   = rec_valid_o ? mem_high_q[rd_ptr_q] : '0;
  assign rec_period_o = rec_valid_o ? mem_per_q[rd_ptr_q] : '0;
  assign pulse_cnt_o  = cnt_q;
  assign min_period_o = min_q;
  assign max_period_o = max_q;
  assign run_done_o   = done_q;
  assign run_abort_o  = abort_q;
  assign overflow_o   = ovf_q;

  always_comb begin
    pulse_d      = pulse_i;
    first_seen_d = first_seen_q;
    fell_d       = fell_q;
    high_tmr_d   = sat_inc(high_tmr_q);
    per_tmr_d    = sat_inc(per_tmr_q);
    high_lat_d   = high_lat_q;
    cnt_d        = cnt_q;
    min_d        = min_q;
    max_d        = max_q;
    ovf_d        = ovf_q;
    done_d       = (state_i == StDone) && prev_active;
    abort_d      = (state_i == StIdle) && prev_active;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;

    if (start) begin
      first_seen_d = 1'b0;
      fell_d       = 1'b0;
      high_tmr_d   = '0;
      per_tmr_d    = '0;
      high_lat_d   = '0;
      cnt_d        = '0;
      min_d        = '1;
      max_d        = '0;
      ovf_d        = 1'b0;
    end

    // Timers restart at 1 so that their value on a later edge is the distance to this rise.
    if (rise) begin
      cnt_d        = sat_inc(cnt_d);
      first_seen_d = 1'b1;
      fell_d       = 1'b0;
      high_tmr_d   = CNT_W'(1);
      per_tmr_d    = CNT_W'(1);
    end

    if (fall) begin
      high_lat_d = high_tmr_q;
      fell_d     = 1'b1;
    end

    if (push) begin
      if (per_tmr_q < min_d) min_d = per_tmr_q;
      if (per_tmr_q > max_d) max_d = per_tmr_q;
    end

    if (drop) ovf_d = 1'b1;

    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_ok && !pop)      count_d = count_q + 1'b1;
    else if (!push_ok && pop) count_d = count_q - 1'b1;

    if (clear_i) begin
      pulse_d      = 1'b0;
      first_seen_d = 1'b0;
      fell_d       = 1'b0;
      high_tmr_d   = '0;
      per_tmr_d    = '0;
      high_lat_d   = '0;
      cnt_d        = '0;
      min_d        = '1;
      max_d        = '0;
      ovf_d        = 1'b0;
      done_d       = 1'b0;
      abort_d      = 1'b0;
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      count_d      = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pulse_q      <= 1'b0;
      state_q      <= StIdle;
      first_seen_q <= 1'b0;
      fell_q       <= 1'b0;
      high_tmr_q   <= '0;
      per_tmr_q    <= '0;
      high_lat_q   <= '0;
      cnt_q        <= '0;
      min_q        <= '1;
      max_q        <= '0;
      done_q       <= 1'b0;
      abort_q      <= 1'b0;
      ovf_q        <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      pulse_q      <= pulse_d;
      state_q      <= clear_i ? StIdle : state_i;
      first_seen_q <= first_seen_d;
      fell_q       <= fell_d;
      high_tmr_q   <= high_tmr_d;
      per_tmr_q    <= per_tmr_d;
      high_lat_q   <= high_lat_d;
      cnt_q        <= cnt_d;
      min_q        <= min_d;
      max_q        <= max_d;
      done_q       <= done_d;
      abort_q      <= abort_d;
      ovf_q        <= ovf_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  // Record storage needs no reset: outputs are masked while the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_high_q[wr_ptr_q] <= rec_high;
      mem_per_q[wr_ptr_q]  <= per_tmr_q;
    end
  end

endmodule

// File: tb/tb_user_pulse_monitor.sv
// Directed bench for user_pulse_monitor: fixed stimulus steps with hand-computed expectations
// checked by immediate assertions.
module tb_user_pulse_monitor;

  localparam int unsigned CNT_W = 16;

  logic             clk_i       = 1'b0;
  logic             rst_ni      = 1'b1;
  logic             pulse_i     = 1'b0;
  logic [2:0]       state_i     = 3'd0;
  logic             clear_i     = 1'b0;
  logic             rec_ready_i = 1'b0;
  logic             rec_valid_o;
  logic [CNT_W-1:0] rec_high_o;
  logic [CNT_W-1:0] rec_period_o;
  logic [CNT_W-1:0] pulse_cnt_o;
  logic [CNT_W-1:0] min_period_o;
  logic [CNT_W-1:0] max_period_o;
  logic             run_done_o;
  logic             run_abort_o;
  logic             overflow_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_i = ~clk_i;

  user_pulse_monitor #(
    .CNT_W      (CNT_W),
    .FIFO_DEPTH (4)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .pulse_i      (pulse_i),
    .state_i      (state_i),
    .clear_i      (clear_i),
    .rec_valid_o  (rec_valid_o),
    .rec_ready_i  (rec_ready_i),
    .rec_high_o   (rec_high_o),
    .rec_period_o (rec_period_o),
    .pulse_cnt_o  (pulse_cnt_o),
    .min_period_o (min_period_o),
    .max_period_o (max_period_o),
    .run_done_o   (run_done_o),
    .run_abort_o  (run_abort_o),
    .overflow_o   (overflow_o)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".valid"},  32'(rec_valid_o),  32'd0);
    check({tag, ".high"},   32'(rec_high_o),   32'd0);
    check({tag, ".period"}, 32'(rec_period_o), 32'd0);
    check({tag, ".cnt"},    32'(pulse_cnt_o),  32'd0);
    check({tag, ".min"},    32'(min_period_o), 32'hFFFF);
    check({tag, ".max"},    32'(max_period_o), 32'd0);
    check({tag, ".done"},   32'(run_done_o),   32'd0);
    check({tag, ".abort"},  32'(run_abort_o),  32'd0);
    check({tag, ".ovf"},    32'(overflow_o),   32'd0);
  endtask

  // High for hi cycles then low for lo cycles: record {hi, hi+lo} at the next rise.
  task automatic pulse(input int hi, input int lo);
    pulse_i = 1'b1;
    ticks(hi);
    pulse_i = 1'b0;
    ticks(lo);
  endtask

  initial begin
    #2 rst_ni = 1'b0;
    #1 check_reset_vals("por");
    ticks(2);
    rst_ni = 1'b1;
    tick();

    // Periodic pulses 3 high / 5 low, consumer always ready.
    rec_ready_i = 1'b1;
    state_i     = 3'd1;
    ticks(2);
    for (int i = 0; i < 4; i++) begin
      pulse_i = 1'b1;
      tick();
      if (i > 0) begin
        check("p38.valid",  32'(rec_valid_o),  32'd1);
        check("p38.high",   32'(rec_high_o),   32'd3);
        check("p38.period", 32'(rec_period_o), 32'd8);
      end
      ticks(2);
      pulse_i = 1'b0;
      ticks(5);
    end
    check("p38.cnt",     32'(pulse_cnt_o),  32'd4);
    check("p38.min",     32'(min_period_o), 32'd8);
    check("p38.max",     32'(max_period_o), 32'd8);
    check("p38.drained", 32'(rec_valid_o),  32'd0);

    state_i = 3'd0;
    tick();
    check("idle.abort", 32'(run_abort_o), 32'd1);
    tick();
    check("idle.abort_off", 32'(run_abort_o), 32'd0);

    // Run 1 -> 4 -> 0 after two pulses.
    state_i = 3'd1;
    tick();
    pulse(2, 2);
    pulse(2, 2);
    check("done.cnt", 32'(pulse_cnt_o), 32'd2);
    state_i = 3'd4;
    tick();
    check("done.pulse",    32'(run_done_o),  32'd1);
    check("done.no_abort", 32'(run_abort_o), 32'd0);
    tick();
    check("done.one_cycle", 32'(run_done_o), 32'd0);
    state_i = 3'd0;
    tick();
    check("done.idle_done",  32'(run_done_o),   32'd0);
    check("done.idle_abort", 32'(run_abort_o),  32'd0);
    check("done.cnt_held",   32'(pulse_cnt_o),  32'd2);
    check("done.min_held",   32'(min_period_o), 32'd4);
    check("done.max_held",   32'(max_period_o), 32'd4);

    // Abort from state 2.
    state_i = 3'd2;
    tick();
    pulse(2, 2);
    pulse(2, 2);
    state_i = 3'd0;
    tick();
    check("abort.pulse",   32'(run_abort_o), 32'd1);
    check("abort.no_done", 32'(run_done_o),  32'd0);
    tick();
    check("abort.one_cycle", 32'(run_abort_o), 32'd0);
    check("abort.no_done2",  32'(run_done_o),  32'd0);

    // Overflow with a stalled consumer, then simultaneous pop and push while full.
    rec_ready_i = 1'b0;
    state_i     = 3'd1;
    tick();
    check("ovf.start_cnt", 32'(pulse_cnt_o),  32'd0);
    check("ovf.start_min", 32'(min_period_o), 32'hFFFF);
    check("ovf.start_max", 32'(max_period_o), 32'd0);
    for (int i = 0; i < 5; i++) pulse(2, 2);
    check("ovf.full_no_ovf", 32'(overflow_o),   32'd0);
    check("ovf.head_valid",  32'(rec_valid_o),  32'd1);
    check("ovf.head_high",   32'(rec_high_o),   32'd2);
    check("ovf.head_period", 32'(rec_period_o), 32'd4);
    pulse(2, 4);
    check("ovf.dropped", 32'(overflow_o), 32'd1);
    pulse_i     = 1'b1;
    rec_ready_i = 1'b1;
    tick();
    rec_ready_i = 1'b0;
    tick();
    pulse_i = 1'b0;
    ticks(2);
    check("ovf.cnt", 32'(pulse_cnt_o),  32'd7);
    check("ovf.min", 32'(min_period_o), 32'd4);
    check("ovf.max", 32'(max_period_o), 32'd6);
    for (int k = 0; k < 4; k++) begin
      check("drain.valid",  32'(rec_valid_o),  32'd1);
      check("drain.high",   32'(rec_high_o),   32'd2);
      check("drain.period", 32'(rec_period_o), (k == 3) ? 32'd6 : 32'd4);
      rec_ready_i = 1'b1;
      tick();
      rec_ready_i = 1'b0;
    end
    check("drain.empty",        32'(rec_valid_o),  32'd0);
    check("drain.empty_high",   32'(rec_high_o),   32'd0);
    check("drain.empty_period", 32'(rec_period_o), 32'd0);
    check("drain.ovf_held",     32'(overflow_o),   32'd1);

    // Clear collides with a rise that would push a record.
    pulse(2, 2);
    pulse(2, 2);
    check("clr.pre_valid", 32'(rec_valid_o), 32'd1);
    pulse_i = 1'b1;
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    pulse_i = 1'b0;
    check_reset_vals("clr");
    tick();
    check("clr.no_record", 32'(rec_valid_o), 32'd0);

    // Reset in the middle of a run, then timer saturation.
    pulse(2, 2);
    pulse(2, 2);
    #3 rst_ni = 1'b0;
    #1 check_reset_vals("midrst");
    tick();
    rst_ni = 1'b1;
    tick();
    pulse(70000, 2);
    pulse_i = 1'b1;
    tick();
    pulse_i = 1'b0;
    check("sat.valid",  32'(rec_valid_o),  32'd1);
    check("sat.high",   32'(rec_high_o),   32'hFFFF);
    check("sat.period", 32'(rec_period_o), 32'hFFFF);
    check("sat.min",    32'(min_period_o), 32'hFFFF);
    check("sat.max",    32'(max_period_o), 32'hFFFF);
    check("sat.cnt",    32'(pulse_cnt_o),  32'd2);
    check("sat.ovf",    32'(overflow_o),   32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
